// File: rtl/comp_8_casc.sv
// comp_8_casc: 8-bit unsigned magnitude comparator slice, cascadable MSB-first.
// Registered cascade outputs, one clock of latency, async active-low reset.
//
// Ports:
//   clk    system clock, outputs update on rising edge
//   rst_n  asynchronous active-low reset, clears EQ0/GT0
//   A, B   8-bit unsigned operands for this slice
//   EQ1    cascade in: more-significant bits equal so far
//   GT1    cascade in: A > B already decided upstream
//   EQ0    cascade out: equal through this slice
//   GT0    cascade out: A > B through this slice
module comp_8_casc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       EQ1,
  input  logic       GT1,
  output logic       EQ0,
  output logic       GT0
);

  logic eq0_d;
  logic gt0_d;
  logic eq0_q;
  logic gt0_q;

  // Four 2-bit cells, pair [7:6] first. Each cell sees the
  // running verdict from the pair above it. The GT term must
  // use the incoming EQ, so it is updated before EQ.
  always_comb begin
    eq0_d = EQ1;
    gt0_d = GT1;
    for (int i = 3; i >= 0; i--) begin
      gt0_d = gt0_d
            | (eq0_d & (A[2*i +: 2] > B[2*i +: 2]));
      eq0_d = eq0_d
            & (A[2*i +: 2] == B[2*i +: 2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq0_q <= 1'b0;
      gt0_q <= 1'b0;
    end else begin
      eq0_q <= eq0_d;
      gt0_q <= gt0_d;
    end
  end

  assign EQ0 = eq0_q;
  assign GT0 = gt0_q;

endmodule

// File: tb/tb_comp_8_casc.sv
// tb_comp_8_casc: self-checking bench for comp_8_casc.
// Vector table, sweep, random and async-reset sequences.
module tb_comp_8_casc;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       eq1;
  logic       gt1;
  logic       eq0;
  logic       gt0;

  int checks = 0;
  int errors = 0;

  comp_8_casc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .EQ1   (eq1),
    .GT1   (gt1),
    .EQ0   (eq0),
    .GT0   (gt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       eq1;
    logic       gt1;
    logic       x_eq;
    logic       x_gt;
  } vec_t;

  vec_t vecs[$];

  // Reference: compare the full unsigned numbers directly.
  function automatic logic [1:0] model(
    input logic [7:0] ma, input logic [7:0] mb,
    input logic me, input logic mg);
    int ia;
    int ib;
    logic r_eq;
    logic r_gt;
    ia = int'(ma);
    ib = int'(mb);
    r_eq = me && (ia == ib);
    r_gt = mg || (me && (ia > ib));
    return {r_eq, r_gt};
  endfunction

  task automatic chk(input string nm,
                     input logic xe, input logic xg);
    checks++;
    if (eq0 !== xe || gt0 !== xg) begin
      errors++;
      $display("FAIL %s: got EQ0=%b GT0=%b want EQ0=%b GT0=%b (A=%h B=%h EQ1=%b GT1=%b)",
               nm, eq0, gt0, xe, xg, a, b, eq1, gt1);
    end
  endtask

  // Called at a falling edge: drive, capture, check.
  task automatic apply(input string nm,
                       input logic [7:0] ta, input logic [7:0] tb,
                       input logic te, input logic tg,
                       input logic xe, input logic xg);
    a = ta; b = tb; eq1 = te; gt1 = tg;
    @(posedge clk);
    @(negedge clk);
    chk(nm, xe, xg);
  endtask

  initial begin
    logic [1:0] m;
    logic [3:0] cnt;
    logic [5:0] low;

    rst_n = 1'b0;
    a = 8'h55; b = 8'h55; eq1 = 1'b1; gt1 = 1'b0;

    // Reset held across clock edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_release", 1'b1, 1'b0);

    vecs.push_back('{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'hA3, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h10, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
            vecs[i].eq1, vecs[i].gt1,
            vecs[i].x_eq, vecs[i].x_gt);

    // Top-pair sweep under every cascade code.
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 16; k++) begin
        cnt = 4'(k);
        low = 6'($urandom);
        m = model({cnt[3:2], low}, {cnt[1:0], low},
                  c[1], c[0]);
        apply($sformatf("sweep_c%0d_k%0d", c, k),
              {cnt[3:2], low}, {cnt[1:0], low},
              c[1], c[0], m[1], m[0]);
      end
    end

    // Random vectors; half of them force A==B.
    for (int r = 0; r < 200; r++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic re;
      logic rg;
      ra = 8'($urandom);
      rb = (r % 2 == 0) ? ra : 8'($urandom);
      re = 1'($urandom);
      rg = 1'($urandom);
      m = model(ra, rb, re, rg);
      apply($sformatf("rand%0d", r), ra, rb, re, rg,
            m[1], m[0]);
    end

    // Inputs changed between edges must not reach outputs.
    apply("hold_pre", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    a = 8'h00; b = 8'h00;
    #2;
    chk("hold_mid", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_next", 1'b1, 1'b0);

    // Async reset mid-cycle while GT0=1.
    apply("async_pre", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop", 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("async_reload", 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
